watch_set_ctrl: RTL and testbench

WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

---
 rtl/watch_set_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_set_ctrl.sv
// -----------------------------------------------------------------------------
// watch_set_ctrl
// Two-button time-setting controller for a BCD watch counter.
// Mode cycles RUN -> SET_HOUR -> SET_MIN -> COMMIT -> RUN. Up increments the
// field being edited. COMMIT pulses load for one cycle. An edit that sees no
// accepted press for TIMEOUT_CYC cycles is dropped and the block returns to RUN.
//
// Optional feature macro: WATCH_SET_BLINK_EN
//   When it is defined, the field being edited blinks through blank_mask.
//   When it is undefined, blank_mask is constant 0 and no blink counter exists.
//
// Ports
//   clk                      1 kHz system clock, rising edge
//   rst                      asynchronous active-high reset
//   btn_mode, btn_up         raw active-high buttons (asynchronous to clk)
//   cur_{h,m}_{ten,one}      live BCD time from the watch counter
//   set_{h,m}_{ten,one}      BCD edit registers
//   load                     one-cycle strobe: counter takes the set_* values
//   hold                     high while editing; the counter freezes
//   mode                     0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 COMMIT
//   blank_mask               per-digit blank request, bit5 h_ten .. bit0 s_one
// -----------------------------------------------------------------------------
module watch_set_ctrl #(
    parameter int DEBOUNCE_CYC = 20,
    parameter int TIMEOUT_CYC  = 10000,
    parameter int BLINK_HALF   = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic [3:0] cur_h_ten,
    input  logic [3:0] cur_h_one,
    input  logic [3:0] cur_m_ten,
    input  logic [3:0] cur_m_one,
    output logic [3:0] set_h_ten,
    output logic [3:0] set_h_one,
    output logic [3:0] set_m_ten,
    output logic [3:0] set_m_one,
    output logic       load,
    output logic       hold,
    output logic [1:0] mode,
    output logic [5:0] blank_mask
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOUR   = 2'd1,
        ST_MIN    = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t state_q, state_d;

    // ---------------- button conditioning ----------------
    // Index 0 = mode, 1 = up.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_up, btn_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          s1_q, s2_q;
            logic          last_q;      // value of the current run of samples
            logic [DW-1:0] cnt_q;       // length of that run, saturating
            logic          lvl_q, lvl_prev_q;
            // arm_q is set only once a stable low has been accepted, so a
            // button held through reset release cannot produce an event.
            logic          arm_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_q       <= 1'b0;
                    s2_q       <= 1'b0;
                    last_q     <= 1'b0;
                    cnt_q      <= '0;
                    lvl_q      <= 1'b0;
                    lvl_prev_q <= 1'b0;
                    arm_q      <= 1'b0;
                end else begin
                    s1_q       <= btn_raw[gi];
                    s2_q       <= s1_q;
                    lvl_prev_q <= lvl_q;
                    if (s2_q != last_q) begin
                        last_q <= s2_q;
                        cnt_q  <= DW'(1);
                    end else begin
                        if (cnt_q != DW'(DEBOUNCE_CYC))
                            cnt_q <= cnt_q + DW'(1);
                        // This sample completes DEBOUNCE_CYC identical ones.
                        if (cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                            lvl_q <= last_q;
                            if (!last_q)
                                arm_q <= 1'b1;
                        end
                    end
                end
            end

            assign press[gi] = lvl_q & ~lvl_prev_q & arm_q;
        end
    endgenerate

    logic mode_ev, up_ev;
    assign mode_ev = press[0];
    assign up_ev   = press[1];

    // ---------------- idle timeout ----------------
    logic [IW-1:0] idle_q;
    logic          in_set;
    logic          timeout;

    assign in_set  = (state_q == ST_HOUR) || (state_q == ST_MIN);
    assign timeout = (idle_q == IW'(TIMEOUT_CYC - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // Any accepted event clears the idle counter, so it beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (mode_ev) state_d = ST_HOUR;
            ST_HOUR:   if (mode_ev) state_d = ST_MIN;
                       else if (!up_ev && timeout) state_d = ST_RUN;
            ST_MIN:    if (mode_ev) state_d = ST_COMMIT;
                       else if (!up_ev && timeout) state_d = ST_RUN;
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_q <= '0;
        else if (in_set && (state_d == state_q) && !mode_ev && !up_ev)
            idle_q <= idle_q + IW'(1);
        else
            idle_q <= '0;
    end

    // ---------------- edit registers ----------------
    logic [3:0] h_ten_q, h_one_q, m_ten_q, m_one_q;
    logic       cur_h_ok, cur_m_ok;

    // A corrupt live time is replaced by 00 so the edit registers stay legal.
    assign cur_h_ok = (cur_h_one <= 4'd9) &&
                      ((cur_h_ten < 4'd2) || ((cur_h_ten == 4'd2) && (cur_h_one <= 4'd3)));
    assign cur_m_ok = (cur_m_ten <= 4'd5) && (cur_m_one <= 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_ten_q <= 4'd0;
            h_one_q <= 4'd0;
            m_ten_q <= 4'd0;
            m_one_q <= 4'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mode_ev) begin
                        h_ten_q <= cur_h_ok ? cur_h_ten : 4'd0;
                        h_one_q <= cur_h_ok ? cur_h_one : 4'd0;
                        m_ten_q <= cur_m_ok ? cur_m_ten : 4'd0;
                        m_one_q <= cur_m_ok ? cur_m_one : 4'd0;
                    end
                end
                ST_HOUR: begin
                    if (up_ev && !mode_ev) begin
                        if ((h_ten_q == 4'd2) && (h_one_q == 4'd3)) begin
                            h_ten_q <= 4'd0;
                            h_one_q <= 4'd0;
                        end else if (h_one_q == 4'd9) begin
                            h_ten_q <= h_ten_q + 4'd1;
                            h_one_q <= 4'd0;
                        end else begin
                            h_one_q <= h_one_q + 4'd1;
                        end
                    end
                end
                ST_MIN: begin
                    if (up_ev && !mode_ev) begin
                        if (m_one_q == 4'd9) begin
                            m_one_q <= 4'd0;
                            m_ten_q <= (m_ten_q == 4'd5) ? 4'd0 : m_ten_q + 4'd1;
                        end else begin
                            m_one_q <= m_one_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign set_h_ten = h_ten_q;
    assign set_h_one = h_one_q;
    assign set_m_ten = m_ten_q;
    assign set_m_one = m_one_q;

`ifdef WATCH_SET_BLINK_EN
    localparam int BW = $clog2(2 * BLINK_HALF);
    logic [BW-1:0] blink_q;

    // Restarting on entry and on every up press keeps the field solid for
    // BLINK_HALF cycles after each change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blink_q <= '0;
        else if ((state_d != state_q) || (up_ev && in_set))
            blink_q <= '0;
        else if (blink_q == BW'(2 * BLINK_HALF - 1))
            blink_q <= '0;
        else
            blink_q <= blink_q + BW'(1);
    end
`endif

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mode       = state_q;
        load       = (state_q == ST_COMMIT);
        hold       = (state_q != ST_RUN);
        blank_mask = 6'b000000;
`ifdef WATCH_SET_BLINK_EN
        if (blink_q >= BW'(BLINK_HALF)) begin
            if (state_q == ST_HOUR)
                blank_mask = 6'b110000;
            else if (state_q == ST_MIN)
                blank_mask = 6'b001100;
        end
`endif
    end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_watch_set_ctrl
// Directed and randomized bench for watch_set_ctrl. Expected edit values come
// from a time model kept as plain hour/minute integers with modulo arithmetic.
// -----------------------------------------------------------------------------
module tb_watch_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode, btn_up;
    logic [3:0] cur_h_ten, cur_h_one, cur_m_ten, cur_m_one;
    logic [3:0] set_h_ten, set_h_one, set_m_ten, set_m_one;
    logic       load, hold;
    logic [1:0] mode;
    logic [5:0] blank_mask;

    watch_set_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .cur_h_ten  (cur_h_ten),
        .cur_h_one  (cur_h_one),
        .cur_m_ten  (cur_m_ten),
        .cur_m_one  (cur_m_one),
        .set_h_ten  (set_h_ten),
        .set_h_one  (set_h_one),
        .set_m_ten  (set_m_ten),
        .set_m_one  (set_m_one),
        .load       (load),
        .hold       (hold),
        .mode       (mode),
        .blank_mask (blank_mask)
    );

    always #5 clk = ~clk;

    logic [15:0] set_all;
    assign set_all = {set_h_ten, set_h_one, set_m_ten, set_m_one};

    int n_cmp = 0;
    int n_err = 0;

    // Load monitor: count strobes and capture the committed value.
    int          load_cnt = 0;
    logic [15:0] load_val = '0;
    always @(posedge clk) begin
        if (load) begin
            load_cnt <= load_cnt + 1;
            load_val <= set_all;
        end
    end

    // Cycles spent in SET_MIN while counting is enabled.
    bit count_min = 1'b0;
    int cyc_min   = 0;
    always @(negedge clk) begin
        if (!count_min)
            cyc_min <= 0;
        else if (mode == 2'd2)
            cyc_min <= cyc_min + 1;
    end

    // Reference model
    int cur_h, cur_m;
    int mh, mm;
    int ms;                         // 0 run, 1 hour, 2 minute

    function automatic logic [15:0] bcd(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cur(input int h, input int m);
        cur_h = h;
        cur_m = m;
        {cur_h_ten, cur_h_one, cur_m_ten, cur_m_one} = bcd(h, m);
    endtask

    // Press and release with margins well beyond synchronizer + debounce.
    task automatic press(input bit m, input bit u);
        btn_mode = m;
        btn_up   = u;
        tick(30);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        tick(30);
    endtask

    // Apply one press to the model and the DUT, then compare.
    task automatic do_press(input bit m, input bit u);
        int lc0;
        lc0 = load_cnt;
        if (m) begin
            if (ms == 0) begin
                mh = cur_h;
                mm = cur_m;
                ms = 1;
            end else if (ms == 1) begin
                ms = 2;
            end else begin
                ms = 0;
            end
        end else if (u) begin
            if (ms == 1) mh = (mh + 1) % 24;
            else if (ms == 2) mm = (mm + 1) % 60;
        end
        press(m, u);
        $display("press mode=%0b up=%0b -> mode=%0d hold=%0b set=%04h", m, u, mode, hold, set_all);
        check("mode", 32'(mode), 32'(ms));
        check("hold", 32'(hold), 32'(ms != 0));
        if (ms != 0)
            check("set", 32'(set_all), 32'(bcd(mh, mm)));
        if (m && ms == 0) begin
            check("load_cnt", 32'(load_cnt), 32'(lc0 + 1));
            check("load_val", 32'(load_val), 32'(bcd(mh, mm)));
        end else begin
            check("no_load", 32'(load_cnt), 32'(lc0));
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc0, n, blank_on, blank_bad, guard;

        rst      = 1'b1;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        ms       = 0;
        mh       = 0;
        mm       = 0;
        set_cur(12, 34);
        tick(3);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_hold", 32'(hold), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_set", 32'(set_all), 32'd0);
        check("rst_blank", 32'(blank_mask), 32'd0);
        rst = 1'b0;
        tick(40);

        // Enter at 12:34, two ups, then commit.
        do_press(1, 0);
        do_press(0, 1);
        do_press(0, 1);
        do_press(1, 0);
        do_press(1, 0);

        // mode, up, mode, up, mode from 12:34 -> 13:35
        do_press(1, 0);
        do_press(0, 1);
        do_press(1, 0);
        do_press(0, 1);
        do_press(1, 0);

        // Wrap at 23 and 59, minute wrap leaves hour alone.
        set_cur(23, 59);
        do_press(1, 0);
        do_press(0, 1);
        do_press(1, 0);
        do_press(0, 1);
        do_press(1, 0);

        // Simultaneous mode and up: mode wins.
        set_cur(9, 9);
        do_press(1, 0);
        do_press(1, 1);
        do_press(1, 1);

        // Randomized edits.
        for (int it = 0; it < 6; it++) begin
            set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
            do_press(1, 0);
            n = int'($urandom_range(0, 4));
            for (int i = 0; i < n; i++) do_press(0, 1);
            do_press(1, bit'($urandom_range(0, 1)));
            n = int'($urandom_range(0, 4));
            for (int i = 0; i < n; i++) do_press(0, 1);
            do_press(1, bit'($urandom_range(0, 1)));
        end

        // Bouncing up button yields exactly one increment.
        set_cur(8, 15);
        do_press(1, 0);
        for (int i = 0; i < 10; i++) begin
            btn_up = 1'b1;
            tick(5);
            btn_up = 1'b0;
            tick(5);
        end
        btn_up = 1'b1;
        tick(25);
        btn_up = 1'b0;
        tick(30);
        mh = (mh + 1) % 24;
        $display("bounce -> set=%04h", set_all);
        check("bounce_set", 32'(set_all), 32'(bcd(mh, mm)));

        // Timeout in SET_MIN after exactly TIMEOUT_CYC idle cycles.
        lc0       = load_cnt;
        count_min = 1'b1;
        do_press(1, 0);
        guard = 0;
        while (mode == 2'd2 && guard < 10100) begin
            tick(1);
            guard++;
        end
        tick(2);
        ms = 0;
        $display("timeout -> mode=%0d hold=%0b cycles_in_min=%0d", mode, hold, cyc_min);
        check("to_mode", 32'(mode), 32'd0);
        check("to_hold", 32'(hold), 32'd0);
        check("to_cycles", 32'(cyc_min), 32'd10000);
        check("to_noload", 32'(load_cnt), 32'(lc0));
        count_min = 1'b0;

        // Reset mid-edit, with mode held through reset release.
        set_cur(12, 34);
        do_press(1, 0);
        do_press(0, 1);
        lc0 = load_cnt;
        rst = 1'b1;
        #1;
        $display("reset mid-edit -> mode=%0d hold=%0b set=%04h", mode, hold, set_all);
        check("rmid_mode", 32'(mode), 32'd0);
        check("rmid_hold", 32'(hold), 32'd0);
        check("rmid_set", 32'(set_all), 32'd0);
        ms = 0;
        btn_mode = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(60);
        check("held_mode", 32'(mode), 32'd0);
        check("held_noload", 32'(load_cnt), 32'(lc0));
        btn_mode = 1'b0;
        tick(40);
        do_press(1, 0);

        // Blink behaviour in SET_HOUR.
        blank_on  = 0;
        blank_bad = 0;
        for (int i = 0; i < 1200; i++) begin
            tick(1);
            if (blank_mask == 6'b110000) blank_on++;
            else if (blank_mask != 6'b000000) blank_bad++;
        end
        $display("blink -> on=%0d bad=%0d", blank_on, blank_bad);
        check("blink_bad", 32'(blank_bad), 32'd0);
`ifdef WATCH_SET_BLINK_EN
        check("blink_on_range", 32'(blank_on >= 500 && blank_on <= 700), 32'd1);
`else
        check("blink_off", 32'(blank_on), 32'd0);
`endif
        do_press(1, 0);
        do_press(1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
